// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants and state encoding for the data-memory port arbiter.
// The byte-enable width is also used by the core's dm_be decode.
package dmem_port_arbiter_pkg;

  localparam int BE_W             = 4;
  localparam int DEF_STARVE_LIMIT = 16;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_wait_counter.sv
// Saturating wait counter for the secondary requester.
// It also raises the starved flag once the wait reaches LIMIT.
module arb_wait_counter #(
  parameter int LIMIT = 16,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic resetb,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] wcnt_next;

  // next count: clear wins, otherwise count up and hold at LIMIT
  always_comb begin
    wcnt_next = wcnt;
    if (clr) begin
      wcnt_next = {CNT_W{1'b0}};
    end else if (inc && (wcnt != LIM)) begin
      wcnt_next = wcnt + CNT_W'(1);
    end else begin
      wcnt_next = wcnt;
    end
  end

  // count register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wcnt <= {CNT_W{1'b0}};
    end else begin
      wcnt <= wcnt_next;
    end
  end

  assign starved = (wcnt == LIM);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the MMU data port between the core (priority) and a secondary master.
// A starved secondary request steals one cycle by stalling the core.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = 8
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic            core_we,
  input  logic [BE_W-1:0] core_be,
  input  logic            core_is_signed,
  input  logic [31:0]     core_addr,
  input  logic [31:0]     core_di,
  output logic [31:0]     core_do,
  output logic            core_stall,
  input  logic            sec_req,
  input  logic            sec_we,
  input  logic [BE_W-1:0] sec_be,
  input  logic [31:0]     sec_addr,
  input  logic [31:0]     sec_di,
  output logic            sec_gnt,
  output logic            sec_rvalid,
  output logic [31:0]     sec_do,
  output logic            sec_starved,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic            mem_is_signed,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_di,
  input  logic [31:0]     mem_do
);

  arb_state_e      state_r;
  arb_state_e      state_next;
  logic            rd_pend_r;
  logic            core_act_s;
  logic            starved_s;
  logic            wait_inc_s;
  logic            gnt_s;
  logic            stall_s;
  logic            mem_we_s;
  logic [BE_W-1:0] mem_be_s;

  assign core_act_s = (|core_be) | core_we;
  assign wait_inc_s = sec_req & ~sec_gnt;

  arb_wait_counter #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_wait_cnt (
    .clk     (clk),
    .resetb  (resetb),
    .inc     (wait_inc_s),
    .clr     (~wait_inc_s),
    .starved (starved_s)
  );

  // port mux and next-state decode
  always_comb begin
    state_next    = state_r;
    gnt_s         = 1'b0;
    stall_s       = 1'b0;
    mem_we_s      = 1'b0;
    mem_be_s      = {BE_W{1'b0}};
    mem_is_signed = 1'b0;
    mem_addr      = 32'h0;
    mem_di        = 32'h0;
    case (state_r)
      ARB_NORMAL: begin
        if (core_act_s) begin
          mem_we_s      = core_we;
          mem_be_s      = core_be;
          mem_is_signed = core_is_signed;
          mem_addr      = core_addr;
          mem_di        = core_di;
        end else if (sec_req) begin
          gnt_s    = 1'b1;
          mem_we_s = sec_we;
          mem_be_s = sec_be;
          mem_addr = sec_addr;
          mem_di   = sec_di;
        end else begin
          mem_we_s = 1'b0;
          mem_be_s = {BE_W{1'b0}};
        end
        if (starved_s && sec_req && core_act_s) begin
          state_next = ARB_FORCE;
        end else begin
          state_next = ARB_NORMAL;
        end
      end
      // the core replays its access after the stall, so its inputs are dropped here
      ARB_FORCE: begin
        stall_s    = 1'b1;
        gnt_s      = 1'b1;
        mem_we_s   = sec_we;
        mem_be_s   = sec_be;
        mem_addr   = sec_addr;
        mem_di     = sec_di;
        state_next = ARB_NORMAL;
      end
      default: begin
        state_next = ARB_NORMAL;
      end
    endcase
  end

  assign sec_gnt    = gnt_s & resetb;
  assign core_stall = stall_s & resetb;
  assign mem_we     = mem_we_s & resetb;
  assign mem_be     = mem_be_s & {BE_W{resetb}};

  // arbitration state
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r <= ARB_NORMAL;
    end else begin
      state_r <= state_next;
    end
  end

  // marks a granted secondary read whose data returns next cycle
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_pend_r <= 1'b0;
    end else begin
      rd_pend_r <= sec_gnt & ~sec_we;
    end
  end

  assign sec_rvalid  = rd_pend_r;
  assign sec_do      = rd_pend_r ? mem_do : 32'h0;
  assign sec_starved = starved_s;
  assign core_do     = mem_do;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a cycle-level reference model of the arbitration rules.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        resetb;
  logic        core_we, core_is_signed, core_stall;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_di, core_do;
  logic        sec_req, sec_we, sec_gnt, sec_rvalid, sec_starved;
  logic [3:0]  sec_be;
  logic [31:0] sec_addr, sec_di, sec_do;
  logic        mem_we, mem_is_signed;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_di, mem_do;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(8)) dut (
    .clk(clk), .resetb(resetb),
    .core_we(core_we), .core_be(core_be), .core_is_signed(core_is_signed),
    .core_addr(core_addr), .core_di(core_di), .core_do(core_do), .core_stall(core_stall),
    .sec_req(sec_req), .sec_we(sec_we), .sec_be(sec_be), .sec_addr(sec_addr), .sec_di(sec_di),
    .sec_gnt(sec_gnt), .sec_rvalid(sec_rvalid), .sec_do(sec_do), .sec_starved(sec_starved),
    .mem_we(mem_we), .mem_be(mem_be), .mem_is_signed(mem_is_signed),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
  );

  task automatic idle_in();
    core_we = 1'b0; core_be = 4'h0; core_is_signed = 1'b0; core_addr = 32'h0; core_di = 32'h0;
    sec_req = 1'b0; sec_we = 1'b0; sec_be = 4'h0; sec_addr = 32'h0; sec_di = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    core_we = 1'b1; core_be = 4'hF; sec_req = 1'b1; sec_be = 4'hF;
    repeat (2) next_cycle();
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
    n_checks++; if (mem_be !== 4'h0) begin n_fail++; $display("FAIL rst_mem_be: got %h want 0", mem_be); end
    n_checks++; if (sec_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %0b want 0", sec_gnt); end
    n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", core_stall); end
    n_checks++; if (sec_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %0b want 0", sec_rvalid); end
    n_checks++; if (sec_starved !== 1'b0) begin n_fail++; $display("FAIL rst_starved: got %0b want 0", sec_starved); end
    idle_in();
    #2 resetb = 1'b1;
    next_cycle();
    n_checks++; if (sec_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rel_rvalid: got %0b want 0", sec_rvalid); end
  endtask

  task automatic test_sec_read_idle();
    idle_in();
    sec_req = 1'b1; sec_be = 4'hF; sec_addr = 32'h100;
    #1;
    n_checks++; if (sec_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %0b want 1", sec_gnt); end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL rd_addr: got %h want 100", mem_addr); end
    n_checks++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin n_fail++; $display("FAIL rd_ctl: got we=%0b be=%h want 0/f", mem_we, mem_be); end
    n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rd_stall0: got %0b want 0", core_stall); end
    next_cycle();
    sec_req = 1'b0; mem_do = 32'hDEADBEEF;
    #1;
    n_checks++; if (sec_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %0b want 1", sec_rvalid); end
    n_checks++; if (sec_do !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", sec_do); end
    n_checks++; if (core_do !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_core_do: got %h want deadbeef", core_do); end
    n_checks++; if (core_stall !== 1'b0) begin n_fail++; $display("FAIL rd_stall1: got %0b want 0", core_stall); end
    next_cycle();
    n_checks++; if (sec_rvalid !== 1'b0 || sec_do !== 32'h0) begin n_fail++; $display("FAIL rd_after: got v=%0b d=%h want 0/0", sec_rvalid, sec_do); end
  endtask

  task automatic test_core_priority();
    idle_in();
    core_we = 1'b1; core_be = 4'hF; core_addr = 32'h40; core_di = 32'h12345678;
    sec_req = 1'b1; sec_be = 4'hF; sec_addr = 32'h200;
    #1;
    n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL pri_addr: got %h want 40", mem_addr); end
    n_checks++; if (mem_we !== 1'b1 || mem_di !== 32'h12345678) begin n_fail++; $display("FAIL pri_wr: got we=%0b di=%h want 1/12345678", mem_we, mem_di); end
    n_checks++; if (sec_gnt !== 1'b0) begin n_fail++; $display("FAIL pri_gnt: got %0b want 0", sec_gnt); end
    next_cycle();
    n_checks++; if (dut.u_wait_cnt.wcnt !== 8'd1) begin n_fail++; $display("FAIL pri_wcnt1: got %0d want 1", dut.u_wait_cnt.wcnt); end
    core_we = 1'b0; core_be = 4'h0;
    #1;
    n_checks++; if (sec_gnt !== 1'b1 || mem_addr !== 32'h200) begin n_fail++; $display("FAIL pri_idle_gnt: got g=%0b a=%h want 1/200", sec_gnt, mem_addr); end
    next_cycle();
    sec_req = 1'b0;
    n_checks++; if (dut.u_wait_cnt.wcnt !== 8'd0) begin n_fail++; $display("FAIL pri_wcnt0: got %0d want 0", dut.u_wait_cnt.wcnt); end
    n_checks++; if (sec_rvalid !== 1'b1) begin n_fail++; $display("FAIL pri_rvalid: got %0b want 1", sec_rvalid); end
    next_cycle();
  endtask

  task automatic test_starvation();
    idle_in();
    core_be = 4'hF; core_addr = 32'h80;
    sec_req = 1'b1; sec_be = 4'hF; sec_addr = 32'h300;
    for (int k = 1; k <= LIM; k++) begin
      next_cycle();
      core_addr = 32'h80 + 32'(4 * k);
      #1;
      n_checks++; if (core_stall !== 1'b0 || sec_gnt !== 1'b0) begin n_fail++; $display("FAIL stv_wait%0d: got s=%0b g=%0b want 0/0", k, core_stall, sec_gnt); end
      n_checks++; if (sec_starved !== (k == LIM)) begin n_fail++; $display("FAIL stv_flag%0d: got %0b want %0b", k, sec_starved, (k == LIM)); end
    end
    next_cycle();
    core_we = 1'b1; core_addr = 32'h99;
    #1;
    n_checks++; if (core_stall !== 1'b1 || sec_gnt !== 1'b1) begin n_fail++; $display("FAIL stv_force: got s=%0b g=%0b want 1/1", core_stall, sec_gnt); end
    n_checks++; if (mem_addr !== 32'h300) begin n_fail++; $display("FAIL stv_addr: got %h want 300", mem_addr); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL stv_core_we_leak: got %0b want 0", mem_we); end
    next_cycle();
    sec_req = 1'b0; core_we = 1'b0; core_addr = 32'hA0;
    #1;
    n_checks++; if (core_stall !== 1'b0 || sec_gnt !== 1'b0) begin n_fail++; $display("FAIL stv_back: got s=%0b g=%0b want 0/0", core_stall, sec_gnt); end
    n_checks++; if (mem_addr !== 32'hA0) begin n_fail++; $display("FAIL stv_core_addr: got %h want a0", mem_addr); end
    n_checks++; if (sec_starved !== 1'b0 || sec_rvalid !== 1'b1) begin n_fail++; $display("FAIL stv_after: got st=%0b v=%0b want 0/1", sec_starved, sec_rvalid); end
    next_cycle();
    core_be = 4'h0;
  endtask

  task automatic test_back_to_back();
    idle_in();
    sec_req = 1'b1; sec_be = 4'hF; sec_addr = 32'h10;
    #1;
    n_checks++; if (sec_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %0b want 1", sec_gnt); end
    next_cycle();
    sec_addr = 32'h14; mem_do = 32'h11;
    #1;
    n_checks++; if (sec_gnt !== 1'b1 || sec_rvalid !== 1'b1 || sec_do !== 32'h11) begin n_fail++; $display("FAIL b2b_1: got g=%0b v=%0b d=%h want 1/1/11", sec_gnt, sec_rvalid, sec_do); end
    next_cycle();
    sec_req = 1'b0; mem_do = 32'h22;
    #1;
    n_checks++; if (sec_rvalid !== 1'b1 || sec_do !== 32'h22) begin n_fail++; $display("FAIL b2b_2: got v=%0b d=%h want 1/22", sec_rvalid, sec_do); end
    next_cycle();
    mem_do = 32'h33;
    #1;
    n_checks++; if (sec_rvalid !== 1'b0 || sec_do !== 32'h0) begin n_fail++; $display("FAIL b2b_end: got v=%0b d=%h want 0/0", sec_rvalid, sec_do); end
  endtask

  task automatic test_sec_write();
    idle_in();
    sec_req = 1'b1; sec_we = 1'b1; sec_be = 4'b0011; sec_di = 32'hA5A5; sec_addr = 32'h20;
    #1;
    n_checks++; if (mem_we !== 1'b1 || mem_be !== 4'h3) begin n_fail++; $display("FAIL wr_ctl: got we=%0b be=%h want 1/3", mem_we, mem_be); end
    n_checks++; if (mem_di !== 32'hA5A5 || sec_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_data: got di=%h g=%0b want a5a5/1", mem_di, sec_gnt); end
    next_cycle();
    sec_req = 1'b0; sec_we = 1'b0;
    #1;
    n_checks++; if (sec_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid: got %0b want 0", sec_rvalid); end
  endtask

  task automatic test_async_reset();
    idle_in();
    core_be = 4'hF; sec_req = 1'b1; sec_be = 4'hF; sec_addr = 32'h300;
    repeat (LIM + 1) next_cycle();
    n_checks++; if (core_stall !== 1'b1) begin n_fail++; $display("FAIL ar_in_force: got %0b want 1", core_stall); end
    #2 resetb = 1'b0;
    #1;
    n_checks++; if (core_stall !== 1'b0 || sec_gnt !== 1'b0) begin n_fail++; $display("FAIL ar_drop: got s=%0b g=%0b want 0/0", core_stall, sec_gnt); end
    n_checks++; if (mem_we !== 1'b0 || mem_be !== 4'h0) begin n_fail++; $display("FAIL ar_mem: got we=%0b be=%h want 0/0", mem_we, mem_be); end
    n_checks++; if (dut.state_r !== ARB_NORMAL || dut.u_wait_cnt.wcnt !== 8'd0) begin n_fail++; $display("FAIL ar_state: got st=%0d w=%0d want 0/0", dut.state_r, dut.u_wait_cnt.wcnt); end
    idle_in();
    next_cycle();
    #2 resetb = 1'b1;
    next_cycle();
    n_checks++; if (sec_rvalid !== 1'b0 || core_stall !== 1'b0) begin n_fail++; $display("FAIL ar_release: got v=%0b s=%0b want 0/0", sec_rvalid, core_stall); end
    sec_req = 1'b1; sec_be = 4'hF;
    next_cycle();
    sec_req = 1'b0;
    #1;
    n_checks++; if (sec_rvalid !== 1'b1) begin n_fail++; $display("FAIL ar_pend: got %0b want 1", sec_rvalid); end
    #2 resetb = 1'b0;
    #1;
    n_checks++; if (sec_rvalid !== 1'b0 || sec_do !== 32'h0) begin n_fail++; $display("FAIL ar_rd_drop: got v=%0b d=%h want 0/0", sec_rvalid, sec_do); end
    next_cycle();
    #2 resetb = 1'b1;
    next_cycle();
    n_checks++; if (sec_rvalid !== 1'b0) begin n_fail++; $display("FAIL ar_rd_release: got %0b want 0", sec_rvalid); end
  endtask

  task automatic test_random();
    int          m_wait;
    bit          m_force, m_rdpend, last_gnt, nf;
    bit          e_act, e_gnt, e_starved, e_we, e_sgn;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_di;
    idle_in();
    resetb = 1'b0;
    #1 resetb = 1'b1;
    m_wait = 0; m_force = 1'b0; m_rdpend = 1'b0; last_gnt = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!sec_req || last_gnt || ($urandom_range(0, 15) == 0)) begin
        sec_req  = ($urandom_range(0, 2) != 0);
        sec_we   = 1'($urandom_range(0, 1));
        sec_be   = 4'($urandom);
        sec_addr = $urandom;
        sec_di   = $urandom;
      end
      if ($urandom_range(0, 3) != 0) begin
        core_be = 4'($urandom); core_we = 1'($urandom_range(0, 1));
      end else begin
        core_be = 4'h0; core_we = 1'b0;
      end
      core_is_signed = 1'($urandom_range(0, 1));
      core_addr = $urandom; core_di = $urandom;
      if (m_force) core_we = 1'b0;
      mem_do = $urandom;
      #1;
      e_act = (core_be != 4'h0) || core_we;
      e_starved = (m_wait == LIM);
      if (m_force || (!e_act && sec_req)) begin
        e_gnt = 1'b1; e_we = sec_we; e_be = sec_be; e_addr = sec_addr; e_di = sec_di; e_sgn = 1'b0;
      end else if (e_act) begin
        e_gnt = 1'b0; e_we = core_we; e_be = core_be; e_addr = core_addr; e_di = core_di; e_sgn = core_is_signed;
      end else begin
        e_gnt = 1'b0; e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_di = 32'h0; e_sgn = 1'b0;
      end
      n_checks++; if (core_stall !== m_force) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", i, core_stall, m_force); end
      n_checks++; if (sec_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %0b want %0b", i, sec_gnt, e_gnt); end
      n_checks++; if (mem_we !== e_we || mem_be !== e_be) begin n_fail++; $display("FAIL rnd_ctl[%0d]: got %0b/%h want %0b/%h", i, mem_we, mem_be, e_we, e_be); end
      if (e_we || (e_be != 4'h0)) begin
        n_checks++; if (mem_addr !== e_addr || mem_di !== e_di || mem_is_signed !== e_sgn) begin n_fail++; $display("FAIL rnd_bus[%0d]: got %h/%h/%0b want %h/%h/%0b", i, mem_addr, mem_di, mem_is_signed, e_addr, e_di, e_sgn); end
      end
      n_checks++; if (sec_starved !== e_starved) begin n_fail++; $display("FAIL rnd_starved[%0d]: got %0b want %0b", i, sec_starved, e_starved); end
      n_checks++; if (sec_rvalid !== m_rdpend || sec_do !== (m_rdpend ? mem_do : 32'h0)) begin n_fail++; $display("FAIL rnd_rd[%0d]: got %0b/%h want %0b", i, sec_rvalid, sec_do, m_rdpend); end
      n_checks++; if (core_do !== mem_do) begin n_fail++; $display("FAIL rnd_core_do[%0d]: got %h want %h", i, core_do, mem_do); end
      nf       = !m_force && e_starved && sec_req && e_act;
      m_wait   = (sec_req && !e_gnt) ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
      m_rdpend = e_gnt && !sec_we;
      m_force  = nf;
      last_gnt = e_gnt;
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb = 1'b0;
    mem_do = 32'h0;
    idle_in();
    test_reset();
    test_sec_read_idle();
    test_core_priority();
    test_starvation();
    test_back_to_back();
    test_sec_write();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
